dmem_responder: RTL and testbench

- Data-memory end of the CPU store/load interface: accepts `memwrite`/`dataadr`/`writedata` from the core and returns `readdata`.
- Contains three parts: a word-addressed RAM, a memory-mapped test-status window (TOHOST and CYCLE), and a store-trace FIFO that a bench or debug agent drains through a valid/ready port.
- Sits beside the single-cycle core in the top-level.
- Lets simulations end on a self-reported pass/fail code instead of bench-side address snooping.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/trace_fifo.sv | 56 +++++
 rtl/dmem_responder.sv | 121 ++++++++++++
 tb/tb_dmem_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder and its store-trace FIFO.
package dmem_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0000_0400;
  localparam logic [31:0] TOHOST_OFFSET     = 32'h0000_0000;
  localparam logic [31:0] CYCLE_OFFSET      = 32'h0000_0004;
  localparam logic [31:0] PASS_CODE_DEFAULT = 32'd7;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } trace_entry_t;

  typedef enum logic [1:0] {
    RegRam,
    RegTohost,
    RegCycle,
    RegNone
  } region_e;

endpackage

// File: rtl/trace_fifo.sv
// Store-trace FIFO: registered head (no fall-through), drops pushes when full unless a pop
// frees the slot in the same cycle, and flags any drop with a sticky overflow bit.
module trace_fifo
  import dmem_pkg::*;
#(
  parameter int unsigned TRACE_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_push,
  input  logic [63:0] i_entry,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [63:0] o_entry,
  output logic        o_overflow
);

  localparam int unsigned PW = $clog2(TRACE_DEPTH);

  logic [63:0]   r_mem [TRACE_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic          r_overflow;

  logic w_full;
  logic w_pop;
  logic w_push_ok;

  assign o_valid   = (r_count != '0);
  assign w_full    = (r_count == (PW + 1)'(TRACE_DEPTH));
  assign w_pop     = o_valid && i_ready;
  assign w_push_ok = i_push && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (PW + 1)'(w_push_ok) - (PW + 1)'(w_pop);
      if (i_push && !w_push_ok) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_entry;
  end

  assign o_entry    = r_mem[r_rptr];
  assign o_overflow = r_overflow;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, TOHOST/CYCLE status window and optional store trace.
// The trace FIFO is built only when DMEM_TRACE_EN is defined; otherwise trace outputs read 0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT,
  parameter logic [31:0] PASS_CODE   = PASS_CODE_DEFAULT,
  parameter int unsigned TRACE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic        done,
  output logic        pass,
  output logic        err_misalign,
  output logic        trace_overflow
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

  logic [31:0] r_mem [DEPTH];
  logic        r_done;
  logic        r_pass;
  logic        r_err;
  logic [31:0] r_cycle;

  logic [31:0]   w_word_adr;
  logic [AW-1:0] w_idx;
  logic          w_store;
  region_e       w_region;

  // Decode on the word address so reads ignore the byte offset.
  assign w_word_adr = {dataadr[31:2], 2'b00};
  assign w_idx      = dataadr[AW+1:2];
  assign w_store    = memwrite && (dataadr[1:0] == 2'b00);

  always_comb begin
    w_region = RegNone;
    if (w_word_adr < RAM_BYTES)                      w_region = RegRam;
    else if (w_word_adr == MMIO_BASE + TOHOST_OFFSET) w_region = RegTohost;
    else if (w_word_adr == MMIO_BASE + CYCLE_OFFSET)  w_region = RegCycle;
  end

  always_ff @(posedge clk) begin
    if (!rst && w_store && (w_region == RegRam)) r_mem[w_idx] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= 1'b0;
      r_cycle <= '0;
    end else begin
      if (memwrite && !w_store) r_err <= 1'b1;
      // Only the first TOHOST write after reset is recorded.
      if (w_store && (w_region == RegTohost) && !r_done) begin
        r_done <= 1'b1;
        r_pass <= (writedata == PASS_CODE);
      end
      if (!r_done) r_cycle <= r_cycle + 32'd1;
    end
  end

  always_comb begin
    readdata = '0;
    case (w_region)
      RegRam:    readdata = r_mem[w_idx];
      RegTohost: readdata = {30'b0, r_pass, r_done};
      RegCycle:  readdata = r_cycle;
      default:   readdata = '0;
    endcase
  end

  assign done         = r_done;
  assign pass         = r_pass;
  assign err_misalign = r_err;

`ifdef DMEM_TRACE_EN
  trace_entry_t w_push_entry;
  trace_entry_t w_head;

  assign w_push_entry = '{addr: dataadr, data: writedata};

  trace_fifo #(
    .TRACE_DEPTH(TRACE_DEPTH)
  ) u_trace_fifo (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_push    (w_store),
    .i_entry   (w_push_entry),
    .i_ready   (trace_ready),
    .o_valid   (trace_valid),
    .o_entry   (w_head),
    .o_overflow(trace_overflow)
  );

  assign trace_addr = w_head.addr;
  assign trace_data = w_head.data;
`else
  logic        w_unused_ready;
  logic [31:0] w_unused_tdepth;

  assign w_unused_ready  = trace_ready;
  assign w_unused_tdepth = 32'(TRACE_DEPTH);
  assign trace_valid     = 1'b0;
  assign trace_addr      = '0;
  assign trace_data      = '0;
  assign trace_overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table for RAM/MMIO/counter, hand sequences for
// reset, first-TOHOST stickiness and (when DMEM_TRACE_EN is defined) the trace FIFO.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic        trace_ready = 1'b0;
  logic [31:0] readdata;
  logic        trace_valid;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        done;
  logic        pass;
  logic        err_misalign;
  logic        trace_overflow;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp_rd;
    logic [2:0]  exp_flg;  // {done, pass, err_misalign}
  } vec_t;

  vec_t        vecs[22];
  logic [31:0] exp_a[4];
  logic [31:0] exp_d[4];

  dmem_responder u_dut (
    .clk           (clk),
    .rst           (rst),
    .memwrite      (memwrite),
    .dataadr       (dataadr),
    .writedata     (writedata),
    .readdata      (readdata),
    .trace_valid   (trace_valid),
    .trace_ready   (trace_ready),
    .trace_addr    (trace_addr),
    .trace_data    (trace_data),
    .done          (done),
    .pass          (pass),
    .err_misalign  (err_misalign),
    .trace_overflow(trace_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                              input logic chk, input logic [31:0] exp_rd,
                              input logic [2:0] exp_flg);
    vec_t v;
    v.we = we; v.adr = adr; v.wd = wd; v.chk = chk; v.exp_rd = exp_rd; v.exp_flg = exp_flg;
    return v;
  endfunction

  // Leaves the bench at a falling edge with rst low and exactly one reset edge behind it.
  task automatic do_reset();
    @(negedge clk);
    memwrite = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1;
    dataadr = a;
    writedata = d;
    @(negedge clk);
    memwrite = 1'b0;
  endtask

  initial begin
    // Vector i is applied i cycles after reset, so CYCLE reads i until done rises.
    vecs[0]  = mk(1'b0, 32'h404, 32'h0,         1'b1, 32'd0,         3'b000);
    vecs[1]  = mk(1'b1, 32'h010, 32'h1234_5678, 1'b0, 32'h0,         3'b000);
    vecs[2]  = mk(1'b0, 32'h010, 32'h0,         1'b1, 32'h1234_5678, 3'b000);
    vecs[3]  = mk(1'b0, 32'h013, 32'h0,         1'b1, 32'h1234_5678, 3'b000);
    vecs[4]  = mk(1'b1, 32'h010, 32'h55,        1'b1, 32'h1234_5678, 3'b000);
    vecs[5]  = mk(1'b0, 32'h010, 32'h0,         1'b1, 32'h55,        3'b000);
    vecs[6]  = mk(1'b1, 32'h004, 32'hAAAA_5555, 1'b0, 32'h0,         3'b000);
    vecs[7]  = mk(1'b1, 32'h006, 32'hDEAD_BEEF, 1'b0, 32'h0,         3'b000);
    vecs[8]  = mk(1'b0, 32'h004, 32'h0,         1'b1, 32'hAAAA_5555, 3'b001);
    vecs[9]  = mk(1'b1, 32'h0FC, 32'h1111_2222, 1'b0, 32'h0,         3'b001);
    vecs[10] = mk(1'b0, 32'h0FC, 32'h0,         1'b1, 32'h1111_2222, 3'b001);
    vecs[11] = mk(1'b0, 32'h100, 32'h0,         1'b1, 32'h0,         3'b001);
    vecs[12] = mk(1'b1, 32'h408, 32'h5,         1'b0, 32'h0,         3'b001);
    vecs[13] = mk(1'b0, 32'h408, 32'h0,         1'b1, 32'h0,         3'b001);
    vecs[14] = mk(1'b0, 32'h404, 32'h0,         1'b1, 32'd14,        3'b001);
    vecs[15] = mk(1'b0, 32'h400, 32'h0,         1'b1, 32'h0,         3'b001);
    vecs[16] = mk(1'b1, 32'h400, 32'd7,         1'b0, 32'h0,         3'b001);
    vecs[17] = mk(1'b0, 32'h400, 32'h0,         1'b1, 32'h3,         3'b111);
    vecs[18] = mk(1'b0, 32'h404, 32'h0,         1'b1, 32'd17,        3'b111);
    vecs[19] = mk(1'b1, 32'h400, 32'd3,         1'b0, 32'h0,         3'b111);
    vecs[20] = mk(1'b0, 32'h400, 32'h0,         1'b1, 32'h3,         3'b111);
    vecs[21] = mk(1'b0, 32'h404, 32'h0,         1'b1, 32'd17,        3'b111);

    do_reset();
    check("reset flags", {29'b0, done, pass, err_misalign}, 32'h0);
    check_bit("reset trace_valid", trace_valid, 1'b0);

    for (int i = 0; i < 22; i++) begin
      memwrite = vecs[i].we;
      dataadr = vecs[i].adr;
      writedata = vecs[i].wd;
      #1;
      if (vecs[i].chk) check($sformatf("vec%0d readdata", i), readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d flags", i), {29'b0, done, pass, err_misalign},
            {29'b0, vecs[i].exp_flg});
`ifndef DMEM_TRACE_EN
      check_bit($sformatf("vec%0d trace_valid", i), trace_valid, 1'b0);
      check_bit($sformatf("vec%0d trace_overflow", i), trace_overflow, 1'b0);
`endif
      @(negedge clk);
    end
    memwrite = 1'b0;
    dataadr = 32'h404;
    repeat (5) @(negedge clk);
    #1 check("cycle frozen", readdata, 32'd17);
`ifndef DMEM_TRACE_EN
    check("tied trace_addr", trace_addr, 32'h0);
    check("tied trace_data", trace_data, 32'h0);
`endif

    // Reset clears flags and counter but not RAM.
    do_reset();
    dataadr = 32'h404;
    #1 check("post-reset cycle", readdata, 32'h0);
    check("post-reset flags", {29'b0, done, pass, err_misalign}, 32'h0);
    dataadr = 32'h010;
    #1 check("ram kept over reset", readdata, 32'h55);

    // Failing code, then a later passing code must not override it.
    do_reset();
    store(32'h400, 32'd9);
    dataadr = 32'h400;
    #1 check("tohost fail read", readdata, 32'h1);
    check_bit("tohost fail done", done, 1'b1);
    check_bit("tohost fail pass", pass, 1'b0);
    store(32'h400, 32'd7);
    dataadr = 32'h400;
    #1 check("tohost first sticks", readdata, 32'h1);

`ifdef DMEM_TRACE_EN
    // Single entry: appears the cycle after the store, pops on ready.
    do_reset();
    trace_ready = 1'b0;
    store(32'h010, 32'h1234_5678);
    #1 check_bit("t1 valid", trace_valid, 1'b1);
    check("t1 addr", trace_addr, 32'h010);
    check("t1 data", trace_data, 32'h1234_5678);
    trace_ready = 1'b1;
    @(negedge clk);
    #1 check_bit("t1 drained", trace_valid, 1'b0);
    trace_ready = 1'b0;

    // Six stores into four slots: last two dropped, overflow sticky.
    do_reset();
    for (int i = 0; i < 6; i++) store(32'(4 * i), 32'hA0 + 32'(i));
    #1 check_bit("t4 overflow", trace_overflow, 1'b1);
    check_bit("t4 valid", trace_valid, 1'b1);
    check("t4 head", trace_addr, 32'h0);
    @(negedge clk);
    #1 check("t4 head stable", trace_addr, 32'h0);
    trace_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_bit($sformatf("t4 valid%0d", k), trace_valid, 1'b1);
      check($sformatf("t4 addr%0d", k), trace_addr, 32'(4 * k));
      check($sformatf("t4 data%0d", k), trace_data, 32'hA0 + 32'(k));
      @(negedge clk);
      #1;
    end
    check_bit("t4 empty", trace_valid, 1'b0);
    trace_ready = 1'b0;

    // Full FIFO with simultaneous pop and push: push must succeed.
    do_reset();
    for (int i = 0; i < 4; i++) store(32'(4 * i), 32'hB0 + 32'(i));
    trace_ready = 1'b1;
    store(32'h020, 32'h77);
    trace_ready = 1'b0;
    #1 check_bit("t5 no overflow", trace_overflow, 1'b0);
    exp_a[0] = 32'h4;  exp_a[1] = 32'h8;  exp_a[2] = 32'hC;  exp_a[3] = 32'h20;
    exp_d[0] = 32'hB1; exp_d[1] = 32'hB2; exp_d[2] = 32'hB3; exp_d[3] = 32'h77;
    trace_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_bit($sformatf("t5 valid%0d", k), trace_valid, 1'b1);
      check($sformatf("t5 addr%0d", k), trace_addr, exp_a[k]);
      check($sformatf("t5 data%0d", k), trace_data, exp_d[k]);
      @(negedge clk);
      #1;
    end
    check_bit("t5 empty", trace_valid, 1'b0);
    trace_ready = 1'b0;

    // Misaligned store is not traced.
    do_reset();
    store(32'h006, 32'h1);
    #1 check_bit("t6 not traced", trace_valid, 1'b0);
    check_bit("t6 err", err_misalign, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
